stopwatch_ctrl: RTL
===================

// Module: stopwatch_ctrl
// PURPOSE
//   Sequencer for the 4-digit mm:ss stopwatch counter. Debounces the raw pause/reset buttons and
//   synchronises the ADJ/SEL switches. Runs the RUN/PAUSED/ADJUST mode FSM. Emits single-cycle
//   count, adjust-tick and clear strobes that drive the counter datapath. Sits between board I/O
//   and the counter; it holds no time digits itself.
// PARAMETERS
//   CLK_DIV_1HZ  100_000_000  clk_c cycles per count_en_o strobe in RUN (1 Hz)
//   CLK_DIV_2HZ   50_000_000  clk_c cycles per adj_tick_o strobe in ADJUST (2 Hz)
//   DB_CYCLES      1_000_000  consecutive stable synchronised samples for a button level change
//   BLINK_DIV     25_000_000  clk_c cycles per blink_o toggle (STOPWATCH_BLINK_EN only)
// PORTS
//   clk_c        in   1  system clock
//   reset_c      in   1  reset, asynchronous, active-high
//   btn_pause_i  in   1  raw pause/resume button, active-high, bouncy
//   btn_rst_i    in   1  raw stopwatch-clear button, active-high, bouncy
//   sw_adj_i     in   1  raw adjust-mode switch, level
//   sw_sel_i     in   2  raw digit select: 00 sec_ones, 01 sec_tens, 10 min_ones, 11 min_tens
//   count_en_o   out  1  1-cycle strobe: counter advances by one second
//   adj_tick_o   out  1  1-cycle strobe: counter increments the selected digit (mod its range)
//   adj_sel_o    out  2  synchronised sw_sel_i
//   adj_mode_o   out  1  high while the FSM is in ADJUST
//   clr_o        out  1  1-cycle strobe: counter clears to 00:00
//   paused_o     out  1  high while the FSM is in PAUSED
//   blink_o      out  1  display blink enable for the selected digit
// BEHAVIOUR
//   - Reset values: state PAUSED, all strobes 0, adj_mode_o 0, paused_o 1, adj_sel_o 00, blink_o 0,
//     all dividers and debounce counters 0, debounced levels 0.
//   - Sync: every raw input passes through 2 flops. Debounce: the level flips only after DB_CYCLES
//     equal consecutive synchronised samples differ from it. A rising debounced edge gives a 1-cycle
//     press. A press is therefore DB_CYCLES+2 cycles after a clean edge. FSM reacts on the next edge.
//   - FSM, priority per cycle: adj level > rst press > pause press.
//       RUN:     adj=1 -> ADJUST; rst press -> clr_o, -> PAUSED; pause press -> PAUSED
//       PAUSED:  adj=1 -> ADJUST; rst press -> clr_o, stay; pause press -> RUN
//       ADJUST:  adj=0 -> PAUSED; rst press -> clr_o, stay ADJUST; pause press ignored
//     Presses that lose to a higher-priority event in the same cycle are dropped (not queued).
//   - Run prescaler: 0..CLK_DIV_1HZ-1, advances only in RUN, wraps -> count_en_o for 1 cycle.
//     Holds its value in PAUSED/ADJUST, so resume keeps the fractional second. Zeroed on clr_o.
//   - Adjust divider: 0..CLK_DIV_2HZ-1, zeroed on every ADJUST entry, advances only in ADJUST,
//     wraps -> adj_tick_o. count_en_o and adj_tick_o are never high in the same cycle.
//   - clr_o and count_en_o in the same cycle: clr_o is asserted and count_en_o is suppressed.
//   - Counter widths are $clog2(param). Compare against param-1; no free-running overflow.
//   - reset_c mid-operation: immediate return to reset values. A held button needs a fresh press.
// CONFIGURATION
//   STOPWATCH_BLINK_EN defined: blink divider present; blink_o toggles every BLINK_DIV cycles in
//     ADJUST and is forced 0 (divider zeroed) outside ADJUST.
//   Not defined: no blink divider is built; blink_o is tied 0.
// STRUCTURE
//   stopwatch_pkg: typedef enum sw_state_t {SW_RUN, SW_PAUSED, SW_ADJUST}; SEL_SEC_ONES/SEC_TENS/
//     MIN_ONES/MIN_TENS 2-bit constants; digit max constants (9,5,9,5) shared with the counter.
//   Sub-module btn_debounce (2-flop sync + stable counter + rising-edge press), DB_CYCLES param,
//     instantiated for pause and rst. Switches use plain 2-flop sync in this module.
// TESTING  (sim params: CLK_DIV_1HZ=10, CLK_DIV_2HZ=4, DB_CYCLES=3, BLINK_DIV=2)
//   1. Reset release, inputs 0 -> PAUSED, paused_o=1, no strobes for 50 cycles.
//   2. Pause held 10 cycles -> RUN exactly 6 cycles after edge; count_en_o every 10 cycles, 1 wide.
//   3. Pause 2-cycle glitch, and bounce 1-0-1 -> no press, state unchanged.
//   4. RUN, pause at prescaler=6, resume 20 cycles later -> first count_en_o 4 cycles after resume.
//   5. RUN, sw_adj_i=1, sel=10 -> ADJUST, adj_sel_o=10, count_en_o silent, adj_tick_o every 4;
//      adj back to 0 -> PAUSED, adj_tick_o stops; with STOPWATCH_BLINK_EN blink_o period 4 in ADJUST.
//   6. RUN, rst and pause presses same cycle -> one clr_o, prescaler 0, PAUSED; rst in ADJUST -> clr_o, stays.

Source files
------------

// File: rtl/stopwatch_pkg.sv
// Shared types and constants for the mm:ss stopwatch: FSM states, digit select codes
// and per-digit maxima used by both the sequencer and the counter datapath.
package stopwatch_pkg;

    typedef enum logic [1:0] {
        SW_RUN    = 2'd0,
        SW_PAUSED = 2'd1,
        SW_ADJUST = 2'd2
    } sw_state_t;

    typedef logic [1:0] sw_sel_t;

    localparam sw_sel_t SEL_SEC_ONES = 2'b00;
    localparam sw_sel_t SEL_SEC_TENS = 2'b01;
    localparam sw_sel_t SEL_MIN_ONES = 2'b10;
    localparam sw_sel_t SEL_MIN_TENS = 2'b11;

    localparam logic [3:0] SEC_ONES_MAX = 4'd9;
    localparam logic [3:0] SEC_TENS_MAX = 4'd5;
    localparam logic [3:0] MIN_ONES_MAX = 4'd9;
    localparam logic [3:0] MIN_TENS_MAX = 4'd5;

    // Wrap value of the digit addressed by an adjust select code.
    function automatic logic [3:0] digit_max(input sw_sel_t sel);
        logic [3:0] max_v;
        case (sel)
            SEL_SEC_ONES: max_v = SEC_ONES_MAX;
            SEL_SEC_TENS: max_v = SEC_TENS_MAX;
            SEL_MIN_ONES: max_v = MIN_ONES_MAX;
            default:      max_v = MIN_TENS_MAX;
        endcase
        return max_v;
    endfunction

endpackage

// File: rtl/stopwatch_ctrl_if.sv
// Strobe/status bundle from the stopwatch sequencer to the mm:ss counter datapath.
interface stopwatch_ctrl_if;
    import stopwatch_pkg::*;

    logic    count_en_o;
    logic    adj_tick_o;
    sw_sel_t adj_sel_o;
    logic    adj_mode_o;
    logic    clr_o;
    logic    paused_o;
    logic    blink_o;

    modport master (
        output count_en_o, adj_tick_o, adj_sel_o, adj_mode_o, clr_o, paused_o, blink_o
    );

    modport slave (
        input count_en_o, adj_tick_o, adj_sel_o, adj_mode_o, clr_o, paused_o, blink_o
    );

endinterface

// File: rtl/stopwatch_ctrl_btn_debounce.sv
// Button conditioner: 2-flop synchroniser, stable-sample debounce counter and a registered
// single-cycle press on each rising debounced edge. A button held through reset is not a press.
module btn_debounce #(
    parameter int unsigned DB_CYCLES = 1_000_000
) (
    input  logic clk_c,
    input  logic reset_c,
    input  logic btn_i,
    output logic press_o
);

    localparam int unsigned CNT_W = (DB_CYCLES > 1) ? $clog2(DB_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DB_CYCLES - 1);

    logic [1:0]       sync_q, sync_d;
    logic [1:0]       vld_q, vld_d;
    logic             armed_q, armed_d;
    logic             level_q, level_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             press_q, press_d;

    // armed only once a genuine released sample has come through the synchroniser
    always_comb begin
        sync_d  = {sync_q[0], btn_i};
        vld_d   = {vld_q[0], 1'b1};
        armed_d = armed_q | (vld_q[1] & ~sync_q[1]);
        level_d = level_q;
        cnt_d   = cnt_q;
        if (sync_q[1] == level_q) begin
            cnt_d = '0;
        end else if (cnt_q == CNT_LAST) begin
            cnt_d   = '0;
            level_d = sync_q[1];
        end else begin
            cnt_d = cnt_q + CNT_W'(1);
        end
        press_d = level_d & ~level_q & armed_q;
    end

    always_ff @(posedge clk_c or posedge reset_c) begin
        if (reset_c) begin
            sync_q  <= '0;
            vld_q   <= '0;
            armed_q <= 1'b0;
            level_q <= 1'b0;
            cnt_q   <= '0;
            press_q <= 1'b0;
        end else begin
            sync_q  <= sync_d;
            vld_q   <= vld_d;
            armed_q <= armed_d;
            level_q <= level_d;
            cnt_q   <= cnt_d;
            press_q <= press_d;
        end
    end

    assign press_o = press_q;

endmodule

// File: rtl/stopwatch_ctrl.sv
// Stopwatch sequencer: button/switch conditioning, RUN/PAUSED/ADJUST FSM and the 1 Hz / 2 Hz
// strobe dividers feeding the counter. Define STOPWATCH_BLINK_EN to build the digit blink divider.
module stopwatch_ctrl
    import stopwatch_pkg::*;
#(
    parameter int unsigned CLK_DIV_1HZ = 100_000_000,
    parameter int unsigned CLK_DIV_2HZ = 50_000_000,
    parameter int unsigned DB_CYCLES   = 1_000_000,
    parameter int unsigned BLINK_DIV   = 25_000_000
) (
    input  logic             clk_c,
    input  logic             reset_c,
    input  logic             btn_pause_i,
    input  logic             btn_rst_i,
    input  logic             sw_adj_i,
    input  sw_sel_t          sw_sel_i,
    stopwatch_ctrl_if.master cnt_if
);

    localparam int unsigned PRESC_W = (CLK_DIV_1HZ > 1) ? $clog2(CLK_DIV_1HZ) : 1;
    localparam int unsigned ADJ_W   = (CLK_DIV_2HZ > 1) ? $clog2(CLK_DIV_2HZ) : 1;
    localparam logic [PRESC_W-1:0] PRESC_LAST = PRESC_W'(CLK_DIV_1HZ - 1);
    localparam logic [ADJ_W-1:0]   ADJ_LAST   = ADJ_W'(CLK_DIV_2HZ - 1);

    logic pause_press;
    logic rst_press;

    sw_state_t          state_q, state_d;
    logic [PRESC_W-1:0] presc_q, presc_d;
    logic [ADJ_W-1:0]   adj_div_q, adj_div_d;
    logic [1:0]         adj_s_q, adj_s_d;
    sw_sel_t            sel_s1_q, sel_s2_q;
    logic               count_en_q, count_en_d;
    logic               adj_tick_q, adj_tick_d;
    logic               clr_q, clr_d;
    logic               paused_q, paused_d;
    logic               adj_mode_q, adj_mode_d;

    btn_debounce #(.DB_CYCLES(DB_CYCLES)) u_db_pause (
        .clk_c   (clk_c),
        .reset_c (reset_c),
        .btn_i   (btn_pause_i),
        .press_o (pause_press)
    );

    btn_debounce #(.DB_CYCLES(DB_CYCLES)) u_db_rst (
        .clk_c   (clk_c),
        .reset_c (reset_c),
        .btn_i   (btn_rst_i),
        .press_o (rst_press)
    );

    // Mode FSM: adjust level beats clear press beats pause press; losers are dropped
    always_comb begin
        state_d = state_q;
        clr_d   = 1'b0;
        adj_s_d = {adj_s_q[0], sw_adj_i};
        case (state_q)
            SW_RUN: begin
                if (adj_s_q[1]) begin
                    state_d = SW_ADJUST;
                end else if (rst_press) begin
                    clr_d   = 1'b1;
                    state_d = SW_PAUSED;
                end else if (pause_press) begin
                    state_d = SW_PAUSED;
                end
            end
            SW_PAUSED: begin
                if (adj_s_q[1]) begin
                    state_d = SW_ADJUST;
                end else if (rst_press) begin
                    clr_d = 1'b1;
                end else if (pause_press) begin
                    state_d = SW_RUN;
                end
            end
            SW_ADJUST: begin
                if (!adj_s_q[1]) begin
                    state_d = SW_PAUSED;
                end else if (rst_press) begin
                    clr_d = 1'b1;
                end
            end
            default: state_d = SW_PAUSED;
        endcase

        // prescaler keeps its fraction across pauses; a clear wins over a coincident wrap
        count_en_d = 1'b0;
        presc_d    = presc_q;
        if (clr_d) begin
            presc_d = '0;
        end else if (state_q == SW_RUN) begin
            if (presc_q == PRESC_LAST) begin
                presc_d    = '0;
                count_en_d = 1'b1;
            end else begin
                presc_d = presc_q + PRESC_W'(1);
            end
        end

        adj_tick_d = 1'b0;
        adj_div_d  = '0;
        if (state_q == SW_ADJUST) begin
            if (adj_div_q == ADJ_LAST) begin
                adj_tick_d = 1'b1;
            end else begin
                adj_div_d = adj_div_q + ADJ_W'(1);
            end
        end

        paused_d   = (state_d == SW_PAUSED);
        adj_mode_d = (state_d == SW_ADJUST);
    end

    always_ff @(posedge clk_c or posedge reset_c) begin
        if (reset_c) begin
            state_q    <= SW_PAUSED;
            presc_q    <= '0;
            adj_div_q  <= '0;
            adj_s_q    <= '0;
            sel_s1_q   <= SEL_SEC_ONES;
            sel_s2_q   <= SEL_SEC_ONES;
            count_en_q <= 1'b0;
            adj_tick_q <= 1'b0;
            clr_q      <= 1'b0;
            paused_q   <= 1'b1;
            adj_mode_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            presc_q    <= presc_d;
            adj_div_q  <= adj_div_d;
            adj_s_q    <= adj_s_d;
            sel_s1_q   <= sw_sel_i;
            sel_s2_q   <= sel_s1_q;
            count_en_q <= count_en_d;
            adj_tick_q <= adj_tick_d;
            clr_q      <= clr_d;
            paused_q   <= paused_d;
            adj_mode_q <= adj_mode_d;
        end
    end

`ifdef STOPWATCH_BLINK_EN
    localparam int unsigned BLINK_W = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;
    localparam logic [BLINK_W-1:0] BLINK_LAST = BLINK_W'(BLINK_DIV - 1);

    logic [BLINK_W-1:0] blink_div_q, blink_div_d;
    logic               blink_q, blink_d;

    // blink phase restarts from dark on every ADJUST entry
    always_comb begin
        blink_div_d = blink_div_q;
        blink_d     = blink_q;
        if (state_d != SW_ADJUST || state_q != SW_ADJUST) begin
            blink_div_d = '0;
            blink_d     = 1'b0;
        end else if (blink_div_q == BLINK_LAST) begin
            blink_div_d = '0;
            blink_d     = ~blink_q;
        end else begin
            blink_div_d = blink_div_q + BLINK_W'(1);
        end
    end

    always_ff @(posedge clk_c or posedge reset_c) begin
        if (reset_c) begin
            blink_div_q <= '0;
            blink_q     <= 1'b0;
        end else begin
            blink_div_q <= blink_div_d;
            blink_q     <= blink_d;
        end
    end

    assign cnt_if.blink_o = blink_q;
`else
    assign cnt_if.blink_o = 1'b0;
`endif

    assign cnt_if.count_en_o = count_en_q;
    assign cnt_if.adj_tick_o = adj_tick_q;
    assign cnt_if.adj_sel_o  = sel_s2_q;
    assign cnt_if.adj_mode_o = adj_mode_q;
    assign cnt_if.clr_o      = clr_q;
    assign cnt_if.paused_o   = paused_q;

endmodule
